ins_fetch_seq: RTL and testbench

- Instruction fetch and step sequencer that sits directly upstream of the register/ALU execute stage.
- Holds a small loadable program buffer and drives the execute stage's 16-bit instruction word {opcode[15:12], src1[11:8], src2[7:4], dest[3:0]}.
- Generates the single-cycle `step` pulses the execute stage uses to advance its 3-phase cycle: 0 = latch instruction, 1 = write back and show low half, 2 = show high half.
- Pulses come from a debounced push button (manual mode) or an internal timer (auto mode).

---
 rtl/ins_fetch_seq.sv | 130 +++++++++++++
 tb/tb_ins_fetch_seq.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ins_fetch_seq.sv
// Instruction fetch and step sequencer: loadable program buffer feeding the execute
// stage, three step pulses per instruction from a debounced button or an internal timer.
module ins_fetch_seq #(
  parameter int DEPTH     = 16,
  parameter int DB_CYCLES = 4,
  parameter int GAP       = 8,
  localparam int AW       = $clog2(DEPTH),
  localparam int CW       = AW + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load_en,
  input  logic [15:0]   load_data,
  input  logic          start,
  input  logic          auto_mode,
  input  logic          btn_raw,
  output logic [15:0]   INS,
  output logic          step,
  output logic [AW-1:0] pc,
  output logic [1:0]    phase,
  output logic [CW-1:0] count,
  output logic          full,
  output logic          halted,
  output logic [2:0]    state_dbg
);

  localparam int DBW = $clog2(DB_CYCLES + 1);
  localparam int TW  = $clog2(GAP + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_SETTLE, S_WAIT, S_PULSE, S_NEXT, S_HALT
  } state_t;

  state_t           state, state_nx;
  logic [15:0]      mem [DEPTH];
  logic             mode_auto;
  logic [TW-1:0]    timer;
  logic             btn_s1, btn_s2, btn_level, press;
  logic [DBW-1:0]   db_cnt;
  logic             load_ok, start_ok, last_instr, wait_done;

  assign full       = (count == CW'(DEPTH));
  assign load_ok    = (state == S_IDLE) && load_en && !full;
  assign start_ok   = start && (((state == S_IDLE) && (count != '0)) || (state == S_HALT));
  assign last_instr = ((CW'(pc) + CW'(1)) == count);
  assign wait_done  = mode_auto ? (timer == TW'(GAP - 1)) : press;
  // Decoded from the state register so an asynchronous reset drops it at once.
  assign step       = (state == S_PULSE);
  assign state_dbg  = state;

  // Accepted level flips only after DB_CYCLES consecutive samples disagree with it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      btn_s1    <= 1'b0;
      btn_s2    <= 1'b0;
      btn_level <= 1'b0;
      db_cnt    <= '0;
      press     <= 1'b0;
    end else begin
      btn_s1 <= btn_raw;
      btn_s2 <= btn_s1;
      press  <= 1'b0;
      if (btn_s2 == btn_level) begin
        db_cnt <= '0;
      end else if (db_cnt == DBW'(DB_CYCLES - 1)) begin
        db_cnt    <= '0;
        btn_level <= btn_s2;
        press     <= btn_s2;
      end else begin
        db_cnt <= db_cnt + DBW'(1);
      end
    end
  end

  // Program storage survives reset.
  always_ff @(posedge clk) begin
    if (load_ok) mem[count[AW-1:0]] <= load_data;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_IDLE;
    else      state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:   if (start_ok) state_nx = S_FETCH;
      S_FETCH:  state_nx = S_SETTLE;
      S_SETTLE: state_nx = S_WAIT;
      S_WAIT:   if (wait_done) state_nx = S_PULSE;
      S_PULSE:  state_nx = (phase == 2'd2) ? S_NEXT : S_WAIT;
      S_NEXT:   state_nx = last_instr ? S_HALT : S_FETCH;
      S_HALT:   if (start_ok) state_nx = S_FETCH;
      default:  state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      INS       <= '0;
      pc        <= '0;
      phase     <= '0;
      count     <= '0;
      halted    <= 1'b0;
      mode_auto <= 1'b0;
      timer     <= '0;
    end else begin
      timer <= (state == S_WAIT) ? timer + TW'(1) : '0;
      if (load_ok) count <= count + CW'(1);
      // Mode is captured only when a run starts.
      if (start_ok) begin
        pc        <= '0;
        phase     <= '0;
        halted    <= 1'b0;
        mode_auto <= auto_mode;
      end
      case (state)
        S_FETCH: INS <= mem[pc];
        S_PULSE: phase <= (phase == 2'd2) ? 2'd0 : phase + 2'd1;
        S_NEXT: begin
          if (last_instr) halted <= 1'b1;
          else            pc     <= pc + AW'(1);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ins_fetch_seq.sv
// Bench for ins_fetch_seq: random programs run in auto and manual mode, step stream
// compared against a program-image model, plus reset, full-buffer and rerun cases.
module tb_ins_fetch_seq;
  localparam int DEPTH = 16;
  localparam int DB_CYCLES = 4;
  localparam int GAP = 8;
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          load_en = 1'b0;
  logic [15:0]   load_data = '0;
  logic          start = 1'b0;
  logic          auto_mode = 1'b0;
  logic          btn_raw = 1'b0;
  logic [15:0]   INS;
  logic          step;
  logic [AW-1:0] pc;
  logic [1:0]    phase;
  logic [CW-1:0] count;
  logic          full;
  logic          halted;
  logic [2:0]    state_dbg;

  ins_fetch_seq #(.DEPTH(DEPTH), .DB_CYCLES(DB_CYCLES), .GAP(GAP)) dut (
    .clk(clk), .rst(rst), .load_en(load_en), .load_data(load_data), .start(start),
    .auto_mode(auto_mode), .btn_raw(btn_raw), .INS(INS), .step(step), .pc(pc),
    .phase(phase), .count(count), .full(full), .halted(halted), .state_dbg(state_dbg)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  logic [15:0] prog[$];     // model of what the program buffer should hold
  logic [15:0] exp_q[$];    // expected INS at each step pulse
  logic [15:0] obs_q[$];
  int          obs_t_q[$];

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (step === 1'b1) begin
      obs_q.push_back(INS);
      obs_t_q.push_back(cyc);
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    load_en = 1'b0; start = 1'b0; btn_raw = 1'b0;
    rst = 1'b0;
    #1;
    check("rst_ins", INS, 0);
    check("rst_step", step, 0);
    check("rst_pc", pc, 0);
    check("rst_phase", phase, 0);
    check("rst_count", count, 0);
    check("rst_full", full, 0);
    check("rst_halted", halted, 0);
    @(negedge clk);
    rst = 1'b1;
    prog.delete();
  endtask

  // ---------------- driver tasks ----------------
  task automatic load_word(input logic [15:0] w);
    load_data = w;
    load_en = 1'b1;
    @(negedge clk);
    load_en = 1'b0;
    if (prog.size() < DEPTH) prog.push_back(w);
  endtask

  task automatic kick(input logic mode);
    obs_q.delete();
    obs_t_q.delete();
    exp_q.delete();
    foreach (prog[i]) repeat (3) exp_q.push_back(prog[i]);
    auto_mode = mode;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic press_btn(input int bounces);
    for (int i = 0; i < bounces; i++) begin
      btn_raw = (i % 2 == 0);
      @(negedge clk);
    end
    btn_raw = 1'b1;
    repeat (10) @(negedge clk);
    btn_raw = 1'b0;
    repeat (10) @(negedge clk);
  endtask

  task automatic wait_halt(input int budget);
    int n = 0;
    while (halted !== 1'b1 && n < budget) begin
      @(negedge clk);
      n++;
    end
    check("halt_wait", halted, 1);
  endtask

  // ---------------- scoreboard ----------------
  // Within an instruction steps are GAP+1 apart (WAIT GAP cycles, PULSE one);
  // across instructions NEXT, FETCH and SETTLE add three more cycles.
  task automatic score_run(input logic is_auto);
    int n;
    check("n_steps", obs_q.size(), exp_q.size());
    n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
    if (is_auto) begin
      for (int k = 1; k < n; k++)
        check("step_gap", obs_t_q[k] - obs_t_q[k-1], (k % 3 == 0) ? GAP + 4 : GAP + 1);
    end
    for (int k = 0; k < n; k++) check("step_ins", obs_q[k], exp_q[k]);
    check("end_pc", pc, prog.size() - 1);
    check("end_phase", phase, 0);
    check("end_ins", INS, prog[prog.size() - 1]);
  endtask

  task automatic run_auto(input int n);
    do_reset();
    for (int i = 0; i < n; i++) load_word(16'($urandom));
    check("ld_count", count, prog.size());
    kick(1'b1);
    auto_mode = 1'($urandom);
    wait_halt(n * 40 + 100);
    repeat (3) @(negedge clk);
    score_run(1'b1);
  endtask

  task automatic run_manual(input int n);
    do_reset();
    for (int i = 0; i < n; i++) load_word(16'($urandom));
    kick(1'b0);
    for (int i = 0; i < 3 * n; i++) begin
      if (i == 3 * n - 1) check("man_not_halted", halted, 0);
      press_btn($urandom_range(1, 5));
    end
    wait_halt(50);
    score_run(1'b0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int n;
    #3;
    do_reset();

    // Three-word auto program
    load_word(16'h1234);
    load_word(16'h2345);
    load_word(16'h3456);
    check("cnt3", count, 3);
    check("full3", full, 0);
    kick(1'b1);
    wait_halt(300);
    repeat (3) @(negedge clk);
    score_run(1'b1);

    // Rerun from HALT; a load attempt mid-run must be ignored
    kick(1'b1);
    check("rerun_halt_clr", halted, 0);
    repeat (5) @(negedge clk);
    load_data = 16'hFFFF;
    load_en = 1'b1;
    @(negedge clk);
    load_en = 1'b0;
    wait_halt(300);
    repeat (3) @(negedge clk);
    score_run(1'b1);
    check("rerun_count", count, 3);

    // Reset during phase 1 of the second instruction
    kick(1'b1);
    n = 0;
    while (!(pc == AW'(1) && phase == 2'd1 && step === 1'b1) && n < 300) begin
      @(negedge clk);
      n++;
    end
    check("mid_reached", n < 300, 1);
    rst = 1'b0;
    #1;
    check("mid_step", step, 0);
    check("mid_pc", pc, 0);
    check("mid_phase", phase, 0);
    check("mid_count", count, 0);
    check("mid_ins", INS, 0);
    @(negedge clk);
    rst = 1'b1;
    prog.delete();

    // Start with an empty buffer does nothing
    obs_q.delete();
    obs_t_q.delete();
    auto_mode = 1'b1;
    start = 1'b1;
    repeat (30) @(negedge clk);
    start = 1'b0;
    check("empty_steps", obs_q.size(), 0);
    check("empty_halted", halted, 0);
    check("empty_pc", pc, 0);

    // Manual mode, single instruction, bouncing button
    do_reset();
    load_word(16'hA5C3);
    kick(1'b0);
    for (int i = 0; i < 3; i++) begin
      check("man_pre_halt", halted, 0);
      press_btn(3);
    end
    wait_halt(50);
    score_run(1'b0);

    // Overfill: 17th word dropped
    do_reset();
    for (int i = 0; i < DEPTH + 1; i++) load_word(16'($urandom));
    check("full_count", count, DEPTH);
    check("full_flag", full, 1);
    kick(1'b1);
    wait_halt(DEPTH * 40 + 100);
    repeat (3) @(negedge clk);
    score_run(1'b1);

    // Randomized programs
    repeat (4) run_auto($urandom_range(1, 6));
    repeat (2) run_manual($urandom_range(1, 3));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
